// File: rtl/dm_arbiter.sv
// Data-memory access controller: arbitrates MEM-stage and DMA requests onto one single-port DM.
// Each access is held for LAT cycles. A wait counter bounds how long a pending DMA can be starved.
module dm_arbiter #(
  parameter int LAT          = 2,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_dbg_state,
  output logic [7:0]  o_dbg_wait
);

  localparam int CW = $clog2(LAT) + 1;
  localparam int WW = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);
  localparam logic [WW-1:0] WMAX = WW'(DMA_MAX_WAIT);

  // o_dbg_state encoding: 0 IDLE, 1 CPU_BUSY, 2 DMA_BUSY.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_wait;
  logic            r_lat_we;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [31:0]     r_dma_rdata;
  logic            w_grant_cpu;
  logic            w_grant_dma;
  logic            w_busy;
  logic            w_last;

  // Handshakes: a CPU access completes in the cycle cpu_req is high and cpu_stall is low;
  // dma_req is held by the requester until the one-cycle dma_done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant_cpu = 1'b0;
    w_grant_dma = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dma_req && (r_wait == WMAX)) begin
          w_next      = S_DMA;
          w_grant_dma = 1'b1;
        end else if (cpu_req) begin
          w_next      = S_CPU;
          w_grant_cpu = 1'b1;
        end else if (dma_req) begin
          w_next      = S_DMA;
          w_grant_dma = 1'b1;
        end
      end
      S_CPU, S_DMA: begin
        // No back-to-back grant: a held cpu_req must pass through IDLE again.
        if (r_cnt == LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_last    = w_busy && (r_cnt == LAST);
    mem_we    = w_last && r_lat_we;
    cpu_stall = cpu_req && !((r_state == S_CPU) && w_last);
    dma_gnt   = (r_state == S_DMA);
    dma_done  = dma_gnt && w_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_wait      <= '0;
      r_lat_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_grant_cpu) begin
        r_lat_we    <= cpu_we;
        r_mem_addr  <= cpu_addr;
        r_mem_wdata <= cpu_wdata;
        r_cnt       <= '0;
      end else if (w_grant_dma) begin
        r_lat_we    <= dma_we;
        r_mem_addr  <= dma_addr;
        r_mem_wdata <= dma_wdata;
        r_cnt       <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_grant_dma) begin
        r_wait <= '0;
      end else if (dma_req && (r_state != S_DMA) && (r_wait != WMAX)) begin
        r_wait <= r_wait + WW'(1);
      end

      if (dma_done) r_dma_rdata <= mem_rdata;
    end
  end

  assign cpu_rdata   = mem_rdata;
  assign dma_rdata   = r_dma_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;
  assign o_dbg_wait  = 8'(r_wait);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: three instances (LAT 2/3/1) share one stimulus stream and are each
// compared every cycle against a transaction-level reference model and a behavioural DM.
module tb_dm_arbiter;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 1;
  endfunction

  function automatic int maxw_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic        cpu_stall_o [NI];
  logic [31:0] cpu_rdata_o [NI];
  logic        dma_gnt_o   [NI];
  logic        dma_done_o  [NI];
  logic [31:0] dma_rdata_o [NI];
  logic        mem_we_o    [NI];
  logic [31:0] mem_addr_o  [NI];
  logic [31:0] mem_wdata_o [NI];
  logic [31:0] mem_rdata_i [NI];
  logic [1:0]  dbg_state_o [NI];
  logic [7:0]  dbg_wait_o  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT_G  = lat_of(g);
    localparam int MAXW_G = maxw_of(g);
    dm_arbiter #(.LAT(LAT_G), .DMA_MAX_WAIT(MAXW_G)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata_o[g]),
      .cpu_stall   (cpu_stall_o[g]),
      .dma_req     (dma_req),
      .dma_we      (dma_we),
      .dma_addr    (dma_addr),
      .dma_wdata   (dma_wdata),
      .dma_gnt     (dma_gnt_o[g]),
      .dma_done    (dma_done_o[g]),
      .dma_rdata   (dma_rdata_o[g]),
      .mem_we      (mem_we_o[g]),
      .mem_addr    (mem_addr_o[g]),
      .mem_wdata   (mem_wdata_o[g]),
      .mem_rdata   (mem_rdata_i[g]),
      .o_dbg_state (dbg_state_o[g]),
      .o_dbg_wait  (dbg_wait_o[g])
    );
  end

  // behavioural single-port DM per instance, 32 words, combinational read
  logic [31:0] dm [NI][32];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (pl_en) dm[k][pl_idx] <= pl_data;
      else if (mem_we_o[k]) dm[k][mem_addr_o[k][6:2]] <= mem_wdata_o[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) mem_rdata_i[k] = dm[k][mem_addr_o[k][6:2]];
  end

  // reference model: owner 0 none / 1 cpu / 2 dma, m_left = beats still to run
  int          m_owner [NI];
  int          m_left  [NI];
  int          m_wait  [NI];
  logic        m_we    [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [31:0] m_drd   [NI];
  logic        m_stall [NI];
  logic        m_dseen [NI];
  logic [31:0] ref_dm  [NI][32];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_owner[k] = 0;
    m_left[k]  = 0;
    m_wait[k]  = 0;
    m_we[k]    = 1'b0;
    m_addr[k]  = '0;
    m_wdata[k] = '0;
    m_drd[k]   = '0;
  endtask

  task automatic model_check();
    logic last;
    for (int k = 0; k < NI; k++) begin
      if (!reset) model_reset(k);
      last = (m_owner[k] != 0) && (m_left[k] == 1);
      m_stall[k] = cpu_req && !((m_owner[k] == 1) && last);
      chk("cpu_stall", k, 32'(cpu_stall_o[k]), 32'(m_stall[k]));
      chk("mem_we",    k, 32'(mem_we_o[k]), 32'((m_owner[k] != 0) && m_we[k] && last));
      chk("mem_addr",  k, mem_addr_o[k], m_addr[k]);
      chk("mem_wdata", k, mem_wdata_o[k], m_wdata[k]);
      chk("dma_gnt",   k, 32'(dma_gnt_o[k]), 32'(m_owner[k] == 2));
      chk("dma_done",  k, 32'(dma_done_o[k]), 32'((m_owner[k] == 2) && last));
      chk("dma_rdata", k, dma_rdata_o[k], m_drd[k]);
      chk("state",     k, 32'(dbg_state_o[k]), 32'(m_owner[k]));
      chk("wait",      k, 32'(dbg_wait_o[k]), 32'(m_wait[k]));
      if (cpu_req && (m_owner[k] == 1) && last && !m_we[k])
        chk("cpu_rdata", k, cpu_rdata_o[k], ref_dm[k][m_addr[k][6:2]]);
    end
  endtask

  task automatic model_step();
    int   own, gnt;
    logic last;
    for (int k = 0; k < NI; k++) begin
      if (!reset) begin
        model_reset(k);
      end else begin
        own  = m_owner[k];
        last = (own != 0) && (m_left[k] == 1);
        gnt  = 0;
        if (own == 0) begin
          if (dma_req && (m_wait[k] == maxw_of(k))) gnt = 2;
          else if (cpu_req)                         gnt = 1;
          else if (dma_req)                         gnt = 2;
        end
        if (dma_req && (own != 2) && (m_wait[k] < maxw_of(k))) m_wait[k]++;
        if (gnt == 2) m_wait[k] = 0;
        if (own != 0) begin
          if (last) begin
            if (own == 2) begin
              m_drd[k]   = ref_dm[k][m_addr[k][6:2]];
              m_dseen[k] = 1'b1;
            end
            if (m_we[k]) ref_dm[k][m_addr[k][6:2]] = m_wdata[k];
            m_owner[k] = 0;
          end else begin
            m_left[k]--;
          end
        end else if (gnt != 0) begin
          m_owner[k] = gnt;
          m_left[k]  = lat_of(k);
          m_we[k]    = (gnt == 1) ? cpu_we    : dma_we;
          m_addr[k]  = (gnt == 1) ? cpu_addr  : dma_addr;
          m_wdata[k] = (gnt == 1) ? cpu_wdata : dma_wdata;
        end
      end
    end
  endtask

  // driver tasks
  task automatic cyc_begin();
    #1;
    model_check();
  endtask

  task automatic cyc_end();
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc();
    cyc_begin();
    cyc_end();
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    for (int k = 0; k < NI; k++) m_dseen[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    cyc();
    pl_en = 1'b0;
    for (int k = 0; k < NI; k++) ref_dm[k][idx] = d;
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  initial begin
    logic [31:0] saved;
    int          rst_left;
    reset = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    set_cpu(1'b1, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < NI; k++) model_reset(k);
    @(negedge clk);

    // reset state: stall follows cpu_req, no write, no grant
    cyc_begin();
    chk("rst_stall", 0, 32'(cpu_stall_o[0]), 32'd1);
    chk("rst_we",    0, 32'(mem_we_o[0]), 32'd0);
    cyc_end();
    cpu_req = 1'b0;
    cyc_begin();
    chk("rst_stall0", 0, 32'(cpu_stall_o[0]), 32'd0);
    cyc_end();
    reset = 1'b1;

    for (int i = 0; i < 32; i++)
      preload(5'(i), (i == 4) ? 32'hDEADBEEF : (i == 16) ? 32'hCAFEF00D : $urandom);

    // CPU load of 0x10
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 4; c++) begin
      cyc_begin();
      if (c <= 2) chk("t1_stall", 0, 32'(cpu_stall_o[0]), 32'(c < 2));
      if (c <= 2) chk("t1_we", 0, 32'(mem_we_o[0]), 32'd0);
      if (c == 2) chk("t1_rdata", 0, cpu_rdata_o[0], 32'hDEADBEEF);
      chk("t1_stall_lat3", 1, 32'(cpu_stall_o[1]), 32'(c < 3));
      if (c < 2) chk("t1_stall_lat1", 2, 32'(cpu_stall_o[2]), 32'(c == 0));
      cyc_end();
    end
    idle(4);

    // CPU store of 0x12345678 to 0x20, then read back
    set_cpu(1'b1, 1'b1, 32'h20, 32'h12345678);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) cpu_req = 1'b0;
      cyc_begin();
      chk("t2_we", 0, 32'(mem_we_o[0]), 32'(c == 2));
      if (c == 2) chk("t2_addr", 0, mem_addr_o[0], 32'h20);
      if (c == 2) chk("t2_wdata", 0, mem_wdata_o[0], 32'h12345678);
      cyc_end();
    end
    idle(4);
    chk("t2_dm", 0, dm[0][8], 32'h12345678);
    set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 3; c++) begin
      cyc_begin();
      if (c == 2) chk("t2_rdback", 0, cpu_rdata_o[0], 32'h12345678);
      cyc_end();
    end
    idle(4);

    // simultaneous CPU load and DMA read of 0x40
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 0; c < 7; c++) begin
      if (c == 3) cpu_req = 1'b0;
      if (c == 6) dma_req = 1'b0;
      cyc_begin();
      if (c == 0) chk("t3_wait0", 0, 32'(dbg_wait_o[0]), 32'd0);
      if (c == 1 || c == 2) chk("t3_cpu", 0, 32'(dbg_state_o[0]), 32'd1);
      if (c == 3) chk("t3_idle", 0, 32'(dbg_state_o[0]), 32'd0);
      chk("t3_gnt", 0, 32'(dma_gnt_o[0]), 32'(c == 4 || c == 5));
      chk("t3_done", 0, 32'(dma_done_o[0]), 32'(c == 5));
      if (c == 6) chk("t3_drd", 0, dma_rdata_o[0], 32'hCAFEF00D);
      cyc_end();
    end

    // dma_rdata holds through CPU store and load
    for (int a = 0; a < 2; a++) begin
      set_cpu(1'b1, a == 0, (a == 0) ? 32'h40 : 32'h10, 32'h11112222);
      for (int c = 0; c < 4; c++) begin
        if (c == 3) cpu_req = 1'b0;
        cyc_begin();
        chk("t6_hold", 0, dma_rdata_o[0], 32'hCAFEF00D);
        cyc_end();
      end
    end
    idle(4);

    // starvation bound: cpu_req held, DMA write forced at cycle 6
    set_cpu(1'b1, 1'b0, 32'h18, 32'h0);
    set_dma(1'b1, 1'b1, 32'h08, 32'h5A5A0000);
    for (int c = 0; c < 12; c++) begin
      if (c == 9) dma_req = 1'b0;
      cyc_begin();
      if (c == 0 || c == 3 || c == 6) chk("t4_idle", 0, 32'(dbg_state_o[0]), 32'd0);
      if (c == 1 || c == 4) chk("t4_cpu", 0, 32'(dbg_state_o[0]), 32'd1);
      if (c == 7) chk("t4_dma", 0, 32'(dbg_state_o[0]), 32'd2);
      if (c == 3) chk("t4_wait3", 0, 32'(dbg_wait_o[0]), 32'd3);
      if (c == 6) chk("t4_waitmax", 0, 32'(dbg_wait_o[0]), 32'd4);
      if (c >= 7 && c <= 9) chk("t4_wait_clr", 0, 32'(dbg_wait_o[0]), 32'd0);
      chk("t4_gnt", 0, 32'(dma_gnt_o[0]), 32'(c == 7 || c == 8));
      chk("t4_done", 0, 32'(dma_done_o[0]), 32'(c == 8));
      chk("t4_stall", 0, 32'(cpu_stall_o[0]), 32'(!(c == 2 || c == 5 || c == 11)));
      cyc_end();
    end
    idle(6);
    chk("t4_dm", 0, dm[0][2], 32'h5A5A0000);

    // reset during first busy beat of a LAT=3 store
    saved = ref_dm[1][12];
    set_cpu(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
    for (int c = 0; c < 8; c++) begin
      if (c == 1) reset = 1'b0;
      if (c == 3) reset = 1'b1;
      if (c == 7) cpu_req = 1'b0;
      cyc_begin();
      if (c >= 1 && c <= 3) chk("t5_we", 1, 32'(mem_we_o[1]), 32'd0);
      if (c == 2 || c == 3) chk("t5_dm_kept", 1, dm[1][12], saved);
      if (c == 3) chk("t5_idle", 1, 32'(dbg_state_o[1]), 32'd0);
      if (c == 3) chk("t5_stall", 1, 32'(cpu_stall_o[1]), 32'd1);
      if (c == 4) chk("t5_regrant", 1, 32'(dbg_state_o[1]), 32'd1);
      if (c == 6) chk("t5_we_retry", 1, 32'(mem_we_o[1]), 32'd1);
      cyc_end();
    end
    idle(4);
    chk("t5_dm", 1, dm[1][12], 32'hA5A5A5A5);

    // randomized traffic with occasional asynchronous resets
    rst_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        reset    = 1'b0;
        rst_left = $urandom_range(1, 2);
      end
      if (cpu_req && (m_stall[0] || m_stall[1] || m_stall[2])) begin
        if ($urandom_range(0, 15) == 0) cpu_req = 1'b0;
      end else begin
        set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
      if (dma_req) begin
        if (m_dseen[0] && m_dseen[1] && m_dseen[2]) dma_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        set_dma(1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
      cyc();
    end
    reset = 1'b1;
    idle(6);

    // final memory image against the reference
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 32; w++)
        chk("dm_final", k, dm[k][w], ref_dm[k][w]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
